// File: rtl/riscv_tb_pkg.sv
// Shared types for the store-bus checker: FSM states and fail codes.
package riscv_tb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    PASS = 2'b10,
    FAIL = 2'b11
  } checkState_t;

  localparam logic [1:0] FAIL_NONE     = 2'b00;
  localparam logic [1:0] FAIL_MISMATCH = 2'b01;
  localparam logic [1:0] FAIL_TIMEOUT  = 2'b10;

endpackage

// File: rtl/exp_store_table.sv
// Expected-store table: NUM_CHECKS address/data pairs, synchronous write,
// asynchronous read, cleared to zero by reset.
module exp_store_table #(
  parameter int XLEN       = 32,
  parameter int NUM_CHECKS = 4,
  parameter int IDXW       = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            we,
  input  logic [IDXW-1:0] wrIdx,
  input  logic [XLEN-1:0] wrAddr,
  input  logic [XLEN-1:0] wrData,
  input  logic [IDXW-1:0] rdIdx,
  output logic [XLEN-1:0] rdAddr,
  output logic [XLEN-1:0] rdData
);

  logic [NUM_CHECKS-1:0][XLEN-1:0] addrVec;
  logic [NUM_CHECKS-1:0][XLEN-1:0] dataVec;

  for (genvar gi = 0; gi < NUM_CHECKS; gi++) begin : g_entry
    logic [XLEN-1:0] addrReg;
    logic [XLEN-1:0] dataReg;

    // One table entry; written only when its index is selected.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        addrReg <= '0;
        dataReg <= '0;
      end else if (we && (wrIdx == IDXW'(gi))) begin
        addrReg <= wrAddr;
        dataReg <= wrData;
      end
    end

    assign addrVec[gi] = addrReg;
    assign dataVec[gi] = dataReg;
  end

  assign rdAddr = addrVec[rdIdx];
  assign rdData = dataVec[rdIdx];

endmodule

// File: rtl/mem_write_checker.sv
// Store-bus checker: snoops the data-memory write port and compares each
// store, in order, against a runtime-loaded table, with a watchdog timeout.
module mem_write_checker
  import riscv_tb_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int NUM_CHECKS = 4,
  parameter int TIMEOUT    = 200,
  parameter int STRICT     = 1,
  localparam int IDXW = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1,
  localparam int CNTW = $clog2(NUM_CHECKS + 1),
  localparam int CYCW = $clog2(TIMEOUT + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cfg_we,
  input  logic [IDXW-1:0] cfg_idx,
  input  logic [XLEN-1:0] cfg_addr,
  input  logic [XLEN-1:0] cfg_data,
  input  logic [CNTW-1:0] num_checks,
  input  logic            ign_en,
  input  logic [XLEN-1:0] ign_addr,
  input  logic            start,
  input  logic            clear,
  input  logic            MemWrite,
  input  logic [XLEN-1:0] DataAddr,
  input  logic [XLEN-1:0] WriteData,
  output logic            done,
  output logic            pass,
  output logic            fail,
  output logic [1:0]      fail_code,
  output logic [IDXW-1:0] fail_idx,
  output logic [XLEN-1:0] fail_addr,
  output logic [XLEN-1:0] fail_data,
  output logic [CNTW-1:0] match_cnt,
  output logic [CYCW-1:0] cycle_cnt
);

  localparam logic [CNTW-1:0] MAX_CHECKS = CNTW'(NUM_CHECKS);
  localparam logic [CYCW-1:0] LAST_CYCLE = CYCW'(TIMEOUT - 1);

  checkState_t     stateReg, stateNext;
  logic [CNTW-1:0] activeReg, activeNext;
  logic [CNTW-1:0] matchReg, matchNext;
  logic [CYCW-1:0] cycleReg, cycleNext;
  logic [1:0]      codeReg, codeNext;
  logic [IDXW-1:0] failIdxReg, failIdxNext;
  logic [XLEN-1:0] failAddrReg, failAddrNext;
  logic [XLEN-1:0] failDataReg, failDataNext;
  logic            passReg, passNext;
  logic            failReg, failNext;
  logic            doneReg, doneNext;

  logic [XLEN-1:0] expAddr, expData;
  logic            storeHit, storeIgnored, finished;

  // The table is only writable while idle; entry selection follows match_cnt.
  exp_store_table #(
    .XLEN(XLEN), .NUM_CHECKS(NUM_CHECKS), .IDXW(IDXW)
  ) uTable (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (cfg_we && (stateReg == IDLE)),
    .wrIdx (cfg_idx),
    .wrAddr(cfg_addr),
    .wrData(cfg_data),
    .rdIdx (matchReg[IDXW-1:0]),
    .rdAddr(expAddr),
    .rdData(expData)
  );

  // State, counters, fail capture and status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateReg    <= IDLE;
      activeReg   <= '0;
      matchReg    <= '0;
      cycleReg    <= '0;
      codeReg     <= FAIL_NONE;
      failIdxReg  <= '0;
      failAddrReg <= '0;
      failDataReg <= '0;
      passReg     <= 1'b0;
      failReg     <= 1'b0;
      doneReg     <= 1'b0;
    end else begin
      stateReg    <= stateNext;
      activeReg   <= activeNext;
      matchReg    <= matchNext;
      cycleReg    <= cycleNext;
      codeReg     <= codeNext;
      failIdxReg  <= failIdxNext;
      failAddrReg <= failAddrNext;
      failDataReg <= failDataNext;
      passReg     <= passNext;
      failReg     <= failNext;
      doneReg     <= doneNext;
    end
  end

  // Next-state, counter and capture logic; match beats ignore beats mismatch,
  // and a store verdict on the last cycle beats the timeout.
  always_comb begin
    stateNext    = stateReg;
    activeNext   = activeReg;
    matchNext    = matchReg;
    cycleNext    = cycleReg;
    codeNext     = codeReg;
    failIdxNext  = failIdxReg;
    failAddrNext = failAddrReg;
    failDataNext = failDataReg;
    storeHit     = MemWrite && (DataAddr == expAddr) && (WriteData == expData);
    storeIgnored = MemWrite && ign_en && (DataAddr == ign_addr);
    finished     = 1'b0;

    case (stateReg)
      IDLE: begin
        if (start) begin
          // More active entries than the table holds would wrap the index.
          activeNext = (num_checks > MAX_CHECKS) ? MAX_CHECKS : num_checks;
          matchNext  = '0;
          cycleNext  = '0;
          stateNext  = (num_checks == '0) ? PASS : RUN;
        end
      end
      RUN: begin
        if (storeHit) begin
          matchNext = matchReg + CNTW'(1);
          if (matchNext == activeReg) begin
            stateNext = PASS;
            finished  = 1'b1;
          end
        end else if (MemWrite && !storeIgnored && (STRICT != 0)) begin
          stateNext    = FAIL;
          codeNext     = FAIL_MISMATCH;
          failIdxNext  = matchReg[IDXW-1:0];
          failAddrNext = DataAddr;
          failDataNext = WriteData;
          finished     = 1'b1;
        end
        if (!finished) begin
          if (cycleReg == LAST_CYCLE) begin
            stateNext   = FAIL;
            codeNext    = FAIL_TIMEOUT;
            failIdxNext = matchNext[IDXW-1:0];
          end else begin
            cycleNext = cycleReg + CYCW'(1);
          end
        end
      end
      PASS, FAIL: begin
        if (clear) begin
          stateNext    = IDLE;
          matchNext    = '0;
          cycleNext    = '0;
          codeNext     = FAIL_NONE;
          failIdxNext  = '0;
          failAddrNext = '0;
          failDataNext = '0;
        end
      end
      default: stateNext = IDLE;
    endcase

    passNext = (stateNext == PASS);
    failNext = (stateNext == FAIL);
    doneNext = passNext || failNext;
  end

  assign done      = doneReg;
  assign pass      = passReg;
  assign fail      = failReg;
  assign fail_code = codeReg;
  assign fail_idx  = failIdxReg;
  assign fail_addr = failAddrReg;
  assign fail_data = failDataReg;
  assign match_cnt = matchReg;
  assign cycle_cnt = cycleReg;

endmodule

// File: doc/mem_write_checker.md
# mem_write_checker

Synthesisable, parametrised store-bus checker for the RISC-V cores. It sits beside the core top-level and snoops the data-memory write port (MemWrite, DataAddr, WriteData). It compares each store against a runtime-loaded table of expected address/data pairs, in order, and raises pass or fail, with a watchdog timeout. It replaces hard-coded single-store pass/fail checks in benches and can also be instantiated on FPGA to drive status LEDs.

## Interface

Parameters:
- XLEN, 32, width of address and data buses.
- NUM_CHECKS, 4, depth of the expected-store table (≥1).
- TIMEOUT, 200, maximum RUN cycles before a timeout fail (≥1).
- STRICT, 1, 1 means an unexpected, non-ignored store fails; 0 means such stores are skipped.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- cfg_we  in  1  write one expected-table entry (accepted in IDLE only).
- cfg_idx  in  $clog2(NUM_CHECKS)  table index.
- cfg_addr  in  XLEN  expected store address.
- cfg_data  in  XLEN  expected store data.
- num_checks  in  $clog2(NUM_CHECKS+1)  number of active entries; sampled on start.
- ign_en  in  1  enable the scratch-address ignore.
- ign_addr  in  XLEN  stores to this address are always skipped when ign_en=1.
- start  in  1  begin checking (IDLE only).
- clear  in  1  return from PASS/FAIL to IDLE.
- MemWrite  in  1  observed store strobe.
- DataAddr  in  XLEN  observed store address.
- WriteData  in  XLEN  observed store data.
- done  out  1  state is PASS or FAIL.
- pass  out  1  state is PASS.
- fail  out  1  state is FAIL.
- fail_code  out  2  00 none, 01 mismatch, 10 timeout.
- fail_idx  out  $clog2(NUM_CHECKS)  table index expected when the fail occurred.
- fail_addr, fail_data  out  XLEN  offending store, captured on mismatch (0 on timeout).
- match_cnt  out  $clog2(NUM_CHECKS+1)  entries matched so far.
- cycle_cnt  out  $clog2(TIMEOUT+1)  RUN cycles elapsed.

## Operation

- FSM states: IDLE, RUN, PASS, FAIL.
- IDLE: cfg_we writes the table. start latches num_checks, clears match_cnt and cycle_cnt, and goes to RUN. If num_checks=0, start goes directly to PASS.
- RUN, each cycle with MemWrite=1, priority order:
  1. DataAddr/WriteData equal entry[match_cnt]: match_cnt+1. If this is the last active entry, go to PASS.
  2. ign_en and DataAddr==ign_addr: skip.
  3. Otherwise, if STRICT=1: go to FAIL, code 01, capture fail_idx=match_cnt, DataAddr and WriteData. If STRICT=0: skip.
- Match priority over ignore: an expected store to ign_addr counts as a match.
- Timeout: in RUN, if cycle_cnt==TIMEOUT-1 and that cycle does not complete the table, go to FAIL, code 10, fail_idx=match_cnt.
- A completing match on the timeout cycle gives PASS.
- A mismatch on the timeout cycle gives code 01.
- cycle_cnt saturates and holds in PASS/FAIL. match_cnt holds.
- PASS/FAIL: sticky until clear, which goes to IDLE. Clearing resets fail_* and the counters; the table is kept.
- start is ignored outside IDLE. cfg_we is ignored outside IDLE. clear is ignored in IDLE/RUN.
- Equality is the full XLEN compare; there is no byte masking.

## Timing

- All outputs are registered.
- Reset (async): state=IDLE. All outputs are 0, and every table entry is 0.
- Reset mid-RUN aborts immediately with no pass/fail pulse.
- start at edge N: RUN in cycle N+1, and the first observed store is sampled in cycle N+1 with cycle_cnt=0.
- Store sampled at edge M: match_cnt, pass and fail are updated after edge M, visible in cycle M+1.
- Timeout: at most TIMEOUT store-sampling cycles. fail is visible TIMEOUT cycles after entering RUN.
- cfg write takes effect at the next edge. cfg_we and start in the same cycle: the write lands, and the check uses the new value.

## Structure

- Shared package `riscv_tb_pkg`: the state enum (IDLE/RUN/PASS/FAIL) and fail-code constants (FAIL_NONE, FAIL_MISMATCH, FAIL_TIMEOUT).
- One sub-module, `exp_store_table`: a NUM_CHECKS×(2·XLEN) register file with a synchronous write port, async read indexed by match_cnt, and async reset to 0.
- The FSM and counters stay in mem_write_checker.

## Test plan

- Load {(96,7),(100,25)}, num_checks=2, and drive stores (96,7) then (100,25) -> match_cnt 1 then 2, and pass=1 in the cycle after the second store.
- Load the same table, STRICT=1, and drive the store (104,25) first -> fail=1, fail_code=01, fail_idx=0, fail_addr=104, fail_data=25.
- STRICT=1, ign_en=1, ign_addr=200. Drive (200,99), then (96,7), then (100,25) -> the scratch store is skipped, and pass=1.
- TIMEOUT=200 with no stores after start -> fail=1, code 10, cycle_cnt=199 at detection, and fail asserted exactly 200 cycles after RUN entry. Repeat with the final matching store on cycle_cnt=199 -> pass=1.
- num_checks=0 plus start -> pass=1 one cycle later. Then clear -> IDLE, and all outputs read 0.
- rst_n pulled low mid-RUN after one match -> outputs read 0 immediately. After release, start with the unchanged cfg, which now reads 0 -> the store (0,0) matches entry 0.
